// File: rtl/mmcm_ctrl_pkg.sv
// Shared definitions for the MMCM bring-up / fine phase-shift controller.
// Contents:
//   state_t        controller state encoding
//   DEF_*          default values for the controller parameters
package mmcm_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_ASSERT,
        WAIT_LOCK,
        IDLE,
        PS_PULSE,
        PS_WAIT,
        ERROR
    } state_t;

    localparam int DEF_RST_CYCLES     = 8;
    localparam int DEF_LOCK_TIMEOUT   = 65535;
    localparam int DEF_MAX_RETRY      = 3;
    localparam int DEF_PERIOD_STEPS   = 448;
    localparam int DEF_PSDONE_TIMEOUT = 64;

endpackage

// File: rtl/mmcm_ps_ctrl_sync_2ff.sv
// Two-flop synchronizer for slow level signals crossing into clk.
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, clears both stages to 0
//   d      asynchronous input
//   q      synchronized output, two cycles behind d
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/mmcm_ps_ctrl.sv
// MMCM sequencing controller: reset/lock bring-up with retry, lock tracking,
// and dynamic fine phase shift to an absolute position by the shortest path.
// Ports:
//   clk, rst_n              free-running clock (also psclk), async active-low reset
//   restart                 pulse: rerun bring-up, clear sticky flags and position
//   mmcm_reset/mmcm_locked  MMCM reset output and asynchronous lock input
//   psen/psincdec/psdone    MMCM dynamic phase-shift handshake
//   req_valid/req_target/req_ready  absolute phase request
//   ps_done                 pulse when a request has completed
//   clk_ready, phase_pos    lock status and current phase position
//   err_lock/err_psdone/err_range/lock_lost  sticky status flags
module mmcm_ps_ctrl
    import mmcm_ctrl_pkg::*;
#(
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY      = DEF_MAX_RETRY,
    parameter int PERIOD_STEPS   = DEF_PERIOD_STEPS,
    parameter int PSDONE_TIMEOUT = DEF_PSDONE_TIMEOUT,
    parameter int POS_W          = $clog2(PERIOD_STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    output logic             mmcm_reset,
    input  logic             mmcm_locked,
    output logic             psen,
    output logic             psincdec,
    input  logic             psdone,
    input  logic             req_valid,
    input  logic [POS_W-1:0] req_target,
    output logic             req_ready,
    output logic             ps_done,
    output logic             clk_ready,
    output logic [POS_W-1:0] phase_pos,
    output logic             err_lock,
    output logic             err_psdone,
    output logic             err_range,
    output logic             lock_lost
);

    // One extra bit so target + PERIOD_STEPS cannot overflow.
    localparam logic [POS_W:0]   PERIOD_X = (POS_W+1)'(PERIOD_STEPS);
    localparam logic [POS_W:0]   HALF_X   = PERIOD_X >> 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(PERIOD_STEPS - 1);

    logic lock_s;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mmcm_locked),
        .q     (lock_s)
    );

    state_t           state_reg, state_next;
    logic [31:0]      timer_reg, timer_next;
    logic [31:0]      retry_reg, retry_next;
    logic [POS_W-1:0] count_reg, count_next;
    logic [POS_W-1:0] pos_reg, pos_next;
    logic             dir_reg, dir_next;
    logic             done_reg, done_next;
    logic             err_lock_reg, err_lock_next;
    logic             err_psdone_reg, err_psdone_next;
    logic             err_range_reg, err_range_next;
    logic             lost_reg, lost_next;
    logic [POS_W:0]   diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RST_ASSERT;
            timer_reg      <= '0;
            retry_reg      <= '0;
            count_reg      <= '0;
            pos_reg        <= '0;
            dir_reg        <= 1'b0;
            done_reg       <= 1'b0;
            err_lock_reg   <= 1'b0;
            err_psdone_reg <= 1'b0;
            err_range_reg  <= 1'b0;
            lost_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            retry_reg      <= retry_next;
            count_reg      <= count_next;
            pos_reg        <= pos_next;
            dir_reg        <= dir_next;
            done_reg       <= done_next;
            err_lock_reg   <= err_lock_next;
            err_psdone_reg <= err_psdone_next;
            err_range_reg  <= err_range_next;
            lost_reg       <= lost_next;
        end
    end

    // Forward modular distance from the current position to the target.
    always_comb begin
        if ({1'b0, req_target} >= {1'b0, pos_reg})
            diff = {1'b0, req_target} - {1'b0, pos_reg};
        else
            diff = {1'b0, req_target} + PERIOD_X - {1'b0, pos_reg};
    end

    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        retry_next      = retry_reg;
        count_next      = count_reg;
        pos_next        = pos_reg;
        dir_next        = dir_reg;
        done_next       = 1'b0;
        err_lock_next   = err_lock_reg;
        err_psdone_next = err_psdone_reg;
        err_range_next  = err_range_reg;
        lost_next       = lost_reg;

        if (restart) begin
            state_next      = RST_ASSERT;
            timer_next      = '0;
            retry_next      = '0;
            pos_next        = '0;
            err_lock_next   = 1'b0;
            err_psdone_next = 1'b0;
            err_range_next  = 1'b0;
            lost_next       = 1'b0;
        end else if (!lock_s && (state_reg == IDLE || state_reg == PS_PULSE ||
                                 state_reg == PS_WAIT)) begin
            // Lock loss outranks any psdone or request seen this cycle.
            state_next = RST_ASSERT;
            timer_next = '0;
            pos_next   = '0;
            lost_next  = 1'b1;
        end else begin
            unique case (state_reg)
                RST_ASSERT: begin
                    if (timer_reg == 32'(RST_CYCLES - 1)) begin
                        state_next = WAIT_LOCK;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + 32'd1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_next = IDLE;
                        retry_next = '0;
                    end else if (timer_reg == 32'(LOCK_TIMEOUT - 1)) begin
                        timer_next = '0;
                        if (retry_reg < 32'(MAX_RETRY)) begin
                            retry_next = retry_reg + 32'd1;
                            state_next = RST_ASSERT;
                        end else begin
                            state_next    = ERROR;
                            err_lock_next = 1'b1;
                        end
                    end else begin
                        timer_next = timer_reg + 32'd1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        if ({1'b0, req_target} >= PERIOD_X) begin
                            err_range_next = 1'b1;
                        end else if (diff == '0) begin
                            done_next = 1'b1;
                        end else if (diff <= HALF_X) begin
                            // Half-period tie goes up.
                            dir_next   = 1'b1;
                            count_next = diff[POS_W-1:0];
                            state_next = PS_PULSE;
                        end else begin
                            dir_next   = 1'b0;
                            count_next = POS_W'(PERIOD_X - diff);
                            state_next = PS_PULSE;
                        end
                    end
                end
                PS_PULSE: begin
                    // The psen cycle counts as the first cycle of the psdone wait.
                    state_next = PS_WAIT;
                    timer_next = 32'd1;
                end
                PS_WAIT: begin
                    if (psdone) begin
                        if (dir_reg)
                            pos_next = (pos_reg == LAST_POS) ? '0 : pos_reg + 1'b1;
                        else
                            pos_next = (pos_reg == '0) ? LAST_POS : pos_reg - 1'b1;
                        count_next = count_reg - 1'b1;
                        if (count_reg == POS_W'(1)) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = PS_PULSE;
                        end
                    end else if (timer_reg == 32'(PSDONE_TIMEOUT - 1)) begin
                        state_next      = ERROR;
                        err_psdone_next = 1'b1;
                    end else begin
                        timer_next = timer_reg + 32'd1;
                    end
                end
                ERROR: begin
                    state_next = ERROR;
                end
                default: state_next = RST_ASSERT;
            endcase
        end
    end

    assign mmcm_reset = (state_reg == RST_ASSERT);
    assign psen       = (state_reg == PS_PULSE);
    assign psincdec   = dir_reg;
    assign req_ready  = (state_reg == IDLE);
    assign clk_ready  = (state_reg == IDLE) || (state_reg == PS_PULSE) ||
                        (state_reg == PS_WAIT);
    assign ps_done    = done_reg;
    assign phase_pos  = pos_reg;
    assign err_lock   = err_lock_reg;
    assign err_psdone = err_psdone_reg;
    assign err_range  = err_range_reg;
    assign lock_lost  = lost_reg;

endmodule
